// File: rtl/button_pulse_gen.sv
// Push-button front end: synchronizes and debounces a raw button pin, then
// emits a one-cycle flag on each accepted press plus auto-repeat flags while held.
module button_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter bit          REPEAT_ENABLE   = 1'b1,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic button_signal,
   output logic button_flag,
   output logic button_state,
   output logic button_repeat
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HOLD   = 2'd1;
   localparam logic [1:0] REPEAT = 2'd2;

   localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

   logic        pressed_raw;
   logic        sync_q1, sync_q2;
   logic [31:0] count_q, count_d;
   logic [31:0] timer_q, timer_d;
   logic [1:0]  fsm_q, fsm_d;
   logic        state_d, flag_d, repeat_d;
   logic        accept, press_acc, rel_acc;

   // 1 = pressed, regardless of the pin polarity
   assign pressed_raw = button_signal ^ ACTIVE_LOW;

   assign accept    = (sync_q2 != button_state) && (count_q == DB_LAST);
   assign press_acc = accept && !button_state;
   assign rel_acc   = accept && button_state;

   // Debounce: count consecutive samples that disagree with the accepted level
   always_comb begin
      count_d = 32'd0;
      state_d = button_state;
      if (sync_q2 != button_state) begin
         if (count_q == DB_LAST) begin
            state_d = ~button_state;
         end else begin
            count_d = count_q + 32'd1;
         end
      end
   end

   // Pulse FSM: initial press pulse, delayed first repeat, then periodic repeats
   always_comb begin
      fsm_d    = fsm_q;
      timer_d  = timer_q;
      flag_d   = 1'b0;
      repeat_d = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (press_acc) begin
               flag_d  = 1'b1;
               timer_d = 32'd0;
               fsm_d   = HOLD;
            end
         end
         HOLD: begin
            if (rel_acc) begin
               fsm_d = IDLE;
            end else if (REPEAT_ENABLE && (timer_q == DELAY_LAST)) begin
               flag_d   = 1'b1;
               repeat_d = 1'b1;
               timer_d  = 32'd0;
               fsm_d    = REPEAT;
            end else if (timer_q != 32'hFFFF_FFFF) begin
               // saturate so a long hold without repeat never wraps
               timer_d = timer_q + 32'd1;
            end
         end
         REPEAT: begin
            if (rel_acc) begin
               fsm_d = IDLE;
            end else if (timer_q == PERIOD_LAST) begin
               flag_d   = 1'b1;
               repeat_d = 1'b1;
               timer_d  = 32'd0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: begin
            fsm_d   = IDLE;
            timer_d = 32'd0;
         end
      endcase
   end

   // All state, including the registered output pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q1       <= 1'b0;
         sync_q2       <= 1'b0;
         count_q       <= 32'd0;
         timer_q       <= 32'd0;
         fsm_q         <= IDLE;
         button_state  <= 1'b0;
         button_flag   <= 1'b0;
         button_repeat <= 1'b0;
      end else begin
         sync_q1       <= pressed_raw;
         sync_q2       <= sync_q1;
         count_q       <= count_d;
         timer_q       <= timer_d;
         fsm_q         <= fsm_d;
         button_state  <= state_d;
         button_flag   <= flag_d;
         button_repeat <= repeat_d;
      end
   end

endmodule
